// File: rtl/psum_accum_ctrl_if.sv
// Job/handshake bundle between a psum accumulation controller and its environment.
// The master side issues jobs and products; the slave side is the controller.
interface psum_accum_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [1:0]       cfg_layer_type;
  logic [CNT_W-1:0] cfg_num_ic_tile;
  logic [CNT_W-1:0] cfg_num_oc_tile;
  logic             mac_valid;
  logic             mac_ready;
  logic             out_ready;
  logic             ipsum_rd_en;
  logic [CNT_W-1:0] ipsum_rd_addr;
  logic             ipsum_add_en;
  logic [1:0]       layer_type;
  logic             psum_wr_en;
  logic [CNT_W-1:0] psum_wr_addr;
  logic             psum_last;
  logic             busy;
  logic             done;
  logic [31:0]      stall_cnt;

  modport master (
    output start, cfg_layer_type, cfg_num_ic_tile, cfg_num_oc_tile, mac_valid, out_ready,
    input  mac_ready, ipsum_rd_en, ipsum_rd_addr, ipsum_add_en, layer_type,
           psum_wr_en, psum_wr_addr, psum_last, busy, done, stall_cnt
  );

  modport slave (
    input  start, cfg_layer_type, cfg_num_ic_tile, cfg_num_oc_tile, mac_valid, out_ready,
    output mac_ready, ipsum_rd_en, ipsum_rd_addr, ipsum_add_en, layer_type,
           psum_wr_en, psum_wr_addr, psum_last, busy, done, stall_cnt
  );
endinterface

// File: rtl/psum_accum_ctrl.sv
// Partial-sum accumulation controller: ic-outer/oc-inner tile sequencing with a one-stage write pipeline.
// Optional stall counter enabled by defining PSUM_ACCUM_CTRL_PERF_CNT_EN.
module psum_accum_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  psum_accum_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q;
  logic [1:0]       layer_q;
  logic [CNT_W-1:0] num_ic_q, num_oc_q;
  logic [CNT_W-1:0] ic_q, oc_q;
  logic             wr_en_q, add_en_q, last_q;
  logic [CNT_W-1:0] wr_addr_q;

  logic mac_ready, hs, start_ok, oc_last, ic_last, bubble;

  // With a single oc tile the next product would read the address being written now.
  assign bubble    = (num_oc_q == CNT_W'(1)) && wr_en_q;
  assign mac_ready = (state_q == RUN) && bus.out_ready && !bubble;
  assign hs        = bus.mac_valid && mac_ready;
  assign start_ok  = (state_q == IDLE) && bus.start;
  assign oc_last   = (oc_q == num_oc_q - CNT_W'(1));
  assign ic_last   = (ic_q == num_ic_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      layer_q   <= '0;
      num_ic_q  <= '0;
      num_oc_q  <= '0;
      ic_q      <= '0;
      oc_q      <= '0;
      wr_en_q   <= 1'b0;
      add_en_q  <= 1'b0;
      last_q    <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      wr_en_q   <= hs;
      add_en_q  <= hs && (ic_q != '0);
      last_q    <= hs && ic_last;
      wr_addr_q <= hs ? oc_q : '0;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            layer_q  <= bus.cfg_layer_type;
            num_ic_q <= bus.cfg_num_ic_tile;
            num_oc_q <= bus.cfg_num_oc_tile;
            ic_q     <= '0;
            oc_q     <= '0;
            state_q  <= ((bus.cfg_num_ic_tile != '0) && (bus.cfg_num_oc_tile != '0)) ? RUN : DONE;
          end
        end
        RUN: begin
          if (hs) begin
            if (oc_last) begin
              oc_q <= '0;
              ic_q <= ic_q + CNT_W'(1);
              if (ic_last) state_q <= DRAIN;
            end else begin
              oc_q <= oc_q + CNT_W'(1);
            end
          end
        end
        DRAIN:   state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mac_ready     = mac_ready;
  assign bus.ipsum_rd_en   = hs && (ic_q != '0);
  assign bus.ipsum_rd_addr = (hs && (ic_q != '0)) ? oc_q : '0;
  assign bus.ipsum_add_en  = add_en_q;
  assign bus.layer_type    = layer_q;
  assign bus.psum_wr_en    = wr_en_q;
  assign bus.psum_wr_addr  = wr_addr_q;
  assign bus.psum_last     = last_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = (state_q == DONE);

`ifdef PSUM_ACCUM_CTRL_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if ((state_q == RUN) && !hs && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign bus.stall_cnt   = '0;
`endif

endmodule

// File: doc/psum_accum_ctrl.md
PSUM_ACCUM_CTRL -- requirements
Module: psum_accum_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, default 8, width of tile counters and psum buffer addresses.
REQ-002 SHALL have port: clk  input  1  single clock, rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  one-cycle job start pulse; ignored while busy.
REQ-005 SHALL have port: cfg_layer_type  input  2  layer type, latched at accepted start.
REQ-006 SHALL have port: cfg_num_ic_tile  input  CNT_W  number of input-channel passes, latched at accepted start.
REQ-007 SHALL have port: cfg_num_oc_tile  input  CNT_W  number of output tiles per pass, latched at accepted start.
REQ-008 SHALL have port: mac_valid  input  1  PE array product matrix valid.
REQ-009 SHALL have port: mac_ready  output  1  controller accepts the product matrix.
REQ-010 SHALL have port: out_ready  input  1  psum buffer/writeback can accept a write.
REQ-011 SHALL have port: ipsum_rd_en / ipsum_rd_addr  output  1 / CNT_W  psum buffer read request.
REQ-012 SHALL have port: ipsum_add_en  output  1  reducer adds ipsum to the reduced row sums.
REQ-013 SHALL have port: layer_type  output  2  latched cfg_layer_type, driven to the reducer.
REQ-014 SHALL have port: psum_wr_en / psum_wr_addr / psum_last  output  1 / CNT_W / 1  reducer result write; last marks the final pass.
REQ-015 SHALL have port: busy / done  output  1 / 1  job active / one-cycle completion pulse.
REQ-016 SHALL have port: stall_cnt  output  32  cycles in RUN without a handshake.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
- IDLE->RUN on start with both tile counts nonzero.
- IDLE->DONE on start with either count zero.
- RUN->DRAIN on the final accept.
- DRAIN->DONE after one cycle.
- DONE->IDLE after one cycle.
REQ-018 SHALL treat a handshake as mac_valid && mac_ready.
- mac_ready = (state==RUN) && out_ready && !bubble.
REQ-019 SHALL order loops ic-outer, oc-inner.
- Each handshake increments oc_cnt.
- At oc_cnt==num_oc_tile-1, oc_cnt wraps to 0 and ic_cnt increments.
- The final accept is ic_cnt==num_ic_tile-1 && oc_cnt==num_oc_tile-1.
REQ-020 SHALL assert ipsum_rd_en in the handshake cycle iff ic_cnt!=0, with ipsum_rd_addr=oc_cnt; the buffer read latency is 1 cycle.
REQ-021 SHALL run a second pipeline stage registered from the handshake. In the cycle after each handshake:
- psum_wr_en=1 and psum_wr_addr equal the accepted oc_cnt.
- ipsum_add_en=1 iff the accepted ic_cnt!=0.
- psum_last=1 iff the accepted ic_cnt==num_ic_tile-1.
- All three are 0 in every other cycle.
REQ-022 SHALL hold layer_type constant from the accepted start until the next accepted start.
REQ-023 SHALL insert a one-cycle bubble (bubble=1) when num_oc_tile==1 and a handshake occurred in the previous cycle. This prevents a read of the address being written in the same cycle.
REQ-024 SHALL drive busy=1 in RUN, DRAIN and DONE.
REQ-025 SHALL pulse done for exactly one cycle in DONE.
REQ-026 SHALL ignore start while busy; latched configuration is unchanged.
REQ-027 SHALL NOT change mac_ready combinationally from mac_valid.

Reset
REQ-028 SHALL, on rst_n low, immediately:
- go to IDLE;
- clear counters, the pipeline stage and latched config;
- drive every output 0, including stall_cnt and layer_type.
REQ-029 SHALL abort an in-flight job on reset mid-operation, with no further writes and no done pulse.

Configuration
REQ-030 SHALL gate stall counting with the macro PSUM_ACCUM_CTRL_PERF_CNT_EN.
- Defined: stall_cnt clears at an accepted start and increments in each RUN cycle without a handshake.
- Defined: stall_cnt saturates at 32'hFFFF_FFFF and holds after done.
- Undefined: stall_cnt is constant 0 and no counter register exists.

Verification
REQ-031 SHALL cover the following scenario. Stimulus: ic=2, oc=3, mac_valid and out_ready held high. Required response:
- Writes to addresses 0,1,2,0,1,2.
- ipsum_add_en on the last three writes only; psum_last on the last three only.
- done pulses 2 cycles after the 6th accept.
REQ-032 SHALL cover the following scenario. Stimulus: ic=3, oc=1. Required response:
- mac_ready alternates 1,0.
- Writes to address 0 three times; ipsum_rd_en never coincides with psum_wr_en.
REQ-033 SHALL cover the following scenario. Stimulus: ic=0, oc=5. Required response:
- busy for 1 cycle, done one cycle after start.
- No mac_ready and no writes.
REQ-034 SHALL cover the following scenario. Stimulus: ic=1, oc=4, out_ready low for 5 cycles mid-job. Required response:
- No handshake during the stall.
- stall_cnt=5 with the macro defined, 0 without it.
REQ-035 SHALL cover the following scenario. Stimulus: rst_n low after the 2nd accept of ic=2, oc=2, then a second start. Required response:
- All outputs 0 immediately; no done pulse.
- The next job completes normally.
REQ-036 SHALL cover the following scenario. Stimulus: start during RUN with different configuration. Required response: it is ignored, and layer_type and the write sequence are unchanged.
